envelope_vca: RTL and testbench

- Voltage-controlled-amplifier stage directly downstream of the ADSR envelope generator.
- Scales each oscillator sample by the current envelope value using a sequential shift-add multiplier, one envelope bit per clock.
- Moves samples in and out over valid/ready handshakes; output feeds the mixer/DAC path.

---
 rtl/envelope_vca_if.sv | 23 ++
 rtl/envelope_vca.sv | 110 +++++++++++
 tb/tb_envelope_vca.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/envelope_vca_if.sv
// Sample-in / result-out handshake bundle for the envelope VCA.
// master = source/sink side (oscillator + mixer), slave = the VCA itself.
interface envelope_vca_if #(
  parameter int WAVE_DEPTH = 8
);
  logic [WAVE_DEPTH-1:0] Sample;
  logic                  SampleValid;
  logic                  SampleReady;
  logic [WAVE_DEPTH-1:0] Envolope;
  logic [WAVE_DEPTH-1:0] Out;
  logic                  OutValid;
  logic                  OutReady;

  modport master (
    output Sample, SampleValid, Envolope, OutReady,
    input  SampleReady, Out, OutValid
  );

  modport slave (
    input  Sample, SampleValid, Envolope, OutReady,
    output SampleReady, Out, OutValid
  );
endinterface

// File: rtl/envelope_vca.sv
// Envelope VCA: Out = floor(Sample*Envolope / 2^WAVE_DEPTH) via shift-add, one envelope bit per clock.
// Optional macro VCA_ROUND_EN adds 2^(WAVE_DEPTH-1) before truncation (round-half-up).
module envelope_vca #(
  parameter int WAVE_DEPTH = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  envelope_vca_if.slave  bus,
  output logic           Busy
);
  localparam int W  = WAVE_DEPTH;
  localparam int CW = $clog2(WAVE_DEPTH + 1);

`ifdef VCA_ROUND_EN
  localparam logic [2*W-1:0] RND = (2*W)'(1) << (W - 1);
`else
  localparam logic [2*W-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  s_q, s_d;     // multiplicand, shifted left each MULT step
  logic [W-1:0]    e_q, e_d;     // multiplier, shifted right each MULT step
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   i_q, i_d;
  logic [W-1:0]    out_q, out_d;
  logic            ov_q, ov_d;

  logic            accept;
  logic            last;
  logic [2*W-1:0]  acc_fin;

  assign bus.SampleReady = Reset && (state_q == IDLE);
  assign bus.Out         = out_q;
  assign bus.OutValid    = ov_q;
  assign Busy            = (state_q != IDLE);

  assign accept  = bus.SampleValid && bus.SampleReady;
  // Bits 0..W-1 are summed on the first W MULT cycles; the extra cycle at i==W
  // applies rounding and truncation, so latency matches in both builds.
  assign last    = (i_q == CW'(W));
  assign acc_fin = acc_q + RND;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      e_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      e_q     <= e_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    e_d     = e_q;
    acc_d   = acc_q;
    i_d     = i_q;
    out_d   = out_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          s_d   = {{W{1'b0}}, bus.Sample};
          e_d   = bus.Envolope;
          acc_d = '0;
          i_d   = '0;
          if (bus.Envolope == '0) begin
            out_d   = '0;
            ov_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = MULT;
          end
        end
      end
      MULT: begin
        if (last) begin
          out_d   = acc_fin[2*W-1:W];
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          if (e_q[0]) acc_d = acc_q + s_q;
          s_d = s_q << 1;
          e_d = e_q >> 1;
          i_d = i_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.OutReady) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_envelope_vca.sv
// Randomized + directed bench for envelope_vca against a transaction-level arithmetic model.
module tb_envelope_vca;
  localparam int N = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic Busy;

  envelope_vca_if #(.WAVE_DEPTH(N)) bus();

  envelope_vca #(.WAVE_DEPTH(N)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus),
    .Busy  (Busy)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  function automatic int model_res(input int s, input int e);
    int rnd;
`ifdef VCA_ROUND_EN
    rnd = 1 << (N - 1);
`else
    rnd = 0;
`endif
    if (e == 0) return 0;
    return (s * e + rnd) >> N;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Transaction model: one sample in flight, result due N+1 edges after accept
  // (0 extra edges when the envelope is zero), held until consumed.
  bit m_busy = 0, m_ov = 0;
  int m_cnt = 0, m_res = 0, m_out = 0, m_accepts = 0;

  always @(posedge Clock) begin
    if (!Reset) begin
      m_busy = 0; m_ov = 0; m_out = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (bus.SampleValid) begin
        m_busy = 1;
        m_accepts++;
        m_res = model_res(int'(bus.Sample), int'(bus.Envolope));
        m_cnt = 0;
        if (bus.Envolope == 0) begin
          m_out = 0;
          m_ov  = 1;
        end
      end
    end else if (m_ov) begin
      if (bus.OutReady) begin
        m_ov = 0; m_busy = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == N + 1) begin
        m_out = m_res;
        m_ov  = 1;
      end
    end
  end

  always @(negedge Clock) begin
    if (!Reset) begin
      chk("rst_ready", int'(bus.SampleReady), 0);
      chk("rst_ovalid", int'(bus.OutValid), 0);
      chk("rst_out", int'(bus.Out), 0);
      chk("rst_busy", int'(Busy), 0);
    end else begin
      chk("cmp_ready", int'(bus.SampleReady), int'(!m_busy));
      chk("cmp_busy", int'(Busy), int'(m_busy));
      chk("cmp_ovalid", int'(bus.OutValid), int'(m_ov));
      chk("cmp_out", int'(bus.Out), m_out);
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.SampleReady && n < 40) begin
      @(negedge Clock); #1;
      n++;
    end
    if (n >= 40) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  // One handshake with OutReady high; measures latency, ready-low span and result.
  task automatic run(input string name, input int s, input int e,
                     input int exp, input int lat, input int low_exp);
    int lat_seen = -1, got = -1, low = 0;
    bus.OutReady = 1'b1;
    wait_ready(name);
    bus.Sample      = s[N-1:0];
    bus.Envolope    = e[N-1:0];
    bus.SampleValid = 1'b1;
    @(posedge Clock);
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (bus.OutValid && lat_seen < 0) begin
        lat_seen = k;
        got = int'(bus.Out);
      end
      if (bus.SampleReady) break;
      low++;
      #1;
      bus.SampleValid = 1'b0;
      bus.Sample      = N'($urandom);
      bus.Envolope    = N'($urandom);
    end
    chk({name, "_lat"}, lat_seen, lat);
    chk({name, "_out"}, got, exp);
    chk({name, "_readylow"}, low, low_exp);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int hold, ghost, exp_rounded;
    bus.Sample = '0; bus.Envolope = '0; bus.SampleValid = 1'b0; bus.OutReady = 1'b1;

    // Hand-computed pins on the model itself.
    chk("model_128x128", model_res(128, 128), 64);
`ifdef VCA_ROUND_EN
    chk("model_255x128", model_res(255, 128), 128);
`else
    chk("model_255x128", model_res(255, 128), 127);
`endif
    chk("model_255x255", model_res(255, 255), 254);
    chk("model_100x200", model_res(100, 200), 78);

    repeat (3) @(negedge Clock);
    #1 Reset = 1'b1;
    @(negedge Clock);
    chk("idle_ready", int'(bus.SampleReady), 1);
    chk("idle_busy", int'(Busy), 0);
    chk("idle_ovalid", int'(bus.OutValid), 0);
    chk("idle_out", int'(bus.Out), 0);
    #1;

    run("t128x128", 128, 128, 64, N + 1, N + 2);
`ifdef VCA_ROUND_EN
    run("t255x128", 255, 128, 128, N + 1, N + 2);
`else
    run("t255x128", 255, 128, 127, N + 1, N + 2);
`endif
    run("t255x255", 255, 255, 254, N + 1, N + 2);
    run("t200x0", 200, 0, 0, 0, 1);

    // Backpressure: result must hold and new samples must be ignored.
`ifdef VCA_ROUND_EN
    exp_rounded = 53;
`else
    exp_rounded = 52;
`endif
    bus.OutReady = 1'b0;
    wait_ready("stall");
    bus.Sample = 8'd150; bus.Envolope = 8'd90; bus.SampleValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock); #1 bus.SampleValid = 1'b0;
    for (int k = 0; k < 20 && !bus.OutValid; k++) begin
      @(negedge Clock); #1;
    end
    hold = int'(bus.Out);
    chk("stall_out", hold, exp_rounded);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      chk("stall_ovalid", int'(bus.OutValid), 1);
      chk("stall_hold", int'(bus.Out), hold);
      chk("stall_ready", int'(bus.SampleReady), 0);
      #1;
      bus.SampleValid = ~k[0];
      bus.Sample = N'($urandom); bus.Envolope = N'($urandom);
    end
    bus.SampleValid = 1'b0;
    bus.OutReady = 1'b1;
    @(negedge Clock);
    chk("stall_release_ovalid", int'(bus.OutValid), 0);
    chk("stall_release_ready", int'(bus.SampleReady), 1);
    chk("stall_release_outkeep", int'(bus.Out), hold);
    #1;

    // Reset mid-multiply: the in-flight sample must vanish.
    wait_ready("mrst");
    bus.Sample = 8'd77; bus.Envolope = 8'd99; bus.SampleValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock); #1 bus.SampleValid = 1'b0;
    repeat (3) @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("mrst_out", int'(bus.Out), 0);
    chk("mrst_ovalid", int'(bus.OutValid), 0);
    chk("mrst_ready", int'(bus.SampleReady), 0);
    chk("mrst_busy", int'(Busy), 0);
    @(negedge Clock); #1 Reset = 1'b1;
    ghost = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge Clock);
      if (bus.OutValid) ghost++;
    end
    chk("mrst_no_ghost", ghost, 0);
    #1;
    run("t100x200", 100, 200, 78, N + 1, N + 2);

    // Random traffic; the compare process checks every cycle.
    m_accepts = 0;
    for (int c = 0; c < 600; c++) begin
      int r;
      @(negedge Clock); #1;
      bus.SampleValid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 5);
      bus.Sample   = (r == 0) ? 8'd255 : N'($urandom);
      r = $urandom_range(0, 5);
      bus.Envolope = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : N'($urandom);
      bus.OutReady = ($urandom_range(0, 3) != 0);
    end
    bus.SampleValid = 1'b0;
    bus.OutReady = 1'b1;
    repeat (20) @(negedge Clock);
    chk("rand_enough_accepts", int'(m_accepts >= 20), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
